// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage sitting directly upstream of instruction_memory.
//   Owns the program counter, drives the (combinational-read) memory address,
//   captures the returned byte into the instruction register (IR) and hands
//   the IR to decode over a valid/ready handshake. Supports redirect with
//   flush and, optionally, a halt-opcode stop.
//
// Configuration macro:
//   FETCH_HALT_DETECT_EN - when defined, capturing HALT_OPCODE moves fetch to
//                          HALT. When undefined, HALT_OPCODE is an ordinary
//                          instruction and halted is tied to 0.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   start         in   pulse: leave IDLE and begin fetching
//   imem_addr     out  [ADDR_W] memory address, equals pc
//   imem_data     in   [DATA_W] instruction byte at imem_addr (same cycle)
//   ir            out  [DATA_W] captured instruction
//   ir_pc         out  [ADDR_W] address ir was fetched from
//   ir_valid      out  ir holds an unconsumed instruction
//   ir_ready      in   decode accepts ir this cycle
//   redirect_en   in   jump/branch taken this cycle
//   redirect_addr in   [ADDR_W] jump/branch target
//   halted        out  fetch is in HALT
//   fetch_count   out  [CNT_W] captures since reset, saturating
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                ADDR_W      = 4,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = 4'h0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF,
  parameter int                CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

`ifdef FETCH_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_r, state_n;
  logic [ADDR_W-1:0] pc_r, pc_n;
  logic [DATA_W-1:0] ir_r, ir_n;
  logic [ADDR_W-1:0] ir_pc_r, ir_pc_n;
  logic              ir_valid_r, ir_valid_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic              halted_r, halted_n;
  logic              advance_s;
  logic              redirect_take_s;

  // Capture may happen when running and the IR is empty or being drained.
  assign advance_s       = (state_r == RUN) && (!ir_valid_r || ir_ready);
  // Redirect is honoured in RUN and HALT only; IDLE ignores it.
  assign redirect_take_s = redirect_en && (state_r != IDLE);

  // Next-state and datapath selection in priority order: redirect, capture, drain, hold.
  always_comb begin
    state_n    = state_r;
    pc_n       = pc_r;
    ir_n       = ir_r;
    ir_pc_n    = ir_pc_r;
    ir_valid_n = ir_valid_r;
    cnt_n      = cnt_r;

    if (redirect_take_s) begin
      // Flush: the in-flight IR is dropped even if decode is ready this cycle.
      pc_n       = redirect_addr;
      ir_valid_n = 1'b0;
      state_n    = RUN;
    end else if (advance_s) begin
      ir_n       = imem_data;
      ir_pc_n    = pc_r;
      ir_valid_n = 1'b1;
      // pc steps past the captured address; in HALT it then stays put.
      pc_n       = pc_r + ADDR_W'(1);
      if (cnt_r != {CNT_W{1'b1}}) begin
        cnt_n = cnt_r + CNT_W'(1);
      end else begin
        cnt_n = cnt_r;
      end
      if (HALT_EN && (imem_data == HALT_OPCODE)) begin
        state_n = HALT;
      end else begin
        state_n = RUN;
      end
    end else if (ir_valid_r && ir_ready) begin
      ir_valid_n = 1'b0;
    end else begin
      ir_valid_n = ir_valid_r;
    end

    if ((state_r == IDLE) && start) begin
      state_n = RUN;
    end else begin
      state_n = state_n;
    end

    halted_n = (state_n == HALT);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      ir_r       <= {DATA_W{1'b0}};
      ir_pc_r    <= {ADDR_W{1'b0}};
      ir_valid_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_n;
      pc_r       <= pc_n;
      ir_r       <= ir_n;
      ir_pc_r    <= ir_pc_n;
      ir_valid_r <= ir_valid_n;
      cnt_r      <= cnt_n;
      halted_r   <= halted_n;
    end
  end

  assign imem_addr   = pc_r;
  assign ir          = ir_r;
  assign ir_pc       = ir_pc_r;
  assign ir_valid    = ir_valid_r;
  assign fetch_count = cnt_r;
  assign halted      = HALT_EN ? halted_r : 1'b0;

endmodule
